lcg_stim_driver: RTL and testbench

Synthesizable, parametrised stimulus and response-compaction harness for fuzzed DUTs. It generates deterministic input vectors of arbitrary width using the 32-bit LCG `x' = x*32'h41C64E6D + 32'h3039`, and sequences the DUT reset. It compacts every response vector into a 32-bit MISR signature so that runs on different simulators, or on FPGA, compare with a single word. It sits between the top-level harness control and the DUT's `in_flat`/`out_flat` ports.

---
 rtl/fuzz_pkg.sv | 32 +++
 rtl/lcg_stim_driver_if.sv | 13 +
 rtl/resp_misr.sv | 39 +++
 rtl/lcg_stim_driver.sv | 190 +++++++++++++++++++
 tb/tb_lcg_stim_driver.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/fuzz_pkg.sv
// Shared constants, enums and helpers for the LCG stimulus driver and its response MISR.
package fuzz_pkg;

   localparam logic [31:0] LCG_MUL   = 32'h41C6_4E6D;
   localparam logic [31:0] LCG_INC   = 32'h0000_3039;
   localparam logic [31:0] MISR_POLY = 32'h04C1_1DB7;

   typedef enum logic [1:0] {
      MODE_LCG  = 2'd0,
      MODE_HOLD = 2'd1,
      MODE_WALK = 2'd2,
      MODE_LCG2 = 2'd3
   } mode_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RESET,
      ST_PRIME,
      ST_RUN,
      ST_DONE
   } state_e;

   function automatic int words(input int w);
      return (w + 31) / 32;
   endfunction

   // Product is truncated to 32 bits by the return width.
   function automatic logic [31:0] lcg_step(input logic [31:0] x);
      return x * LCG_MUL + LCG_INC;
   endfunction

endpackage

// File: rtl/lcg_stim_driver_if.sv
// DUT-facing bus: stimulus vector, its strobe, DUT reset, and the DUT response.
interface lcg_stim_driver_if #(
   parameter int IN_W  = 267,
   parameter int OUT_W = 330
);
   logic [IN_W-1:0]  stim;
   logic             stim_valid;
   logic             dut_rst_n;
   logic [OUT_W-1:0] resp;

   modport master (output stim, stim_valid, dut_rst_n, input resp);
   modport slave  (input stim, stim_valid, dut_rst_n, output resp);
endinterface

// File: rtl/resp_misr.sv
// Folds an OUT_W response into 32 bits and absorbs it into a CRC-32 polynomial MISR.
// Signature updates one clock after en; clr wins over en; no backpressure.
module resp_misr
   import fuzz_pkg::*;
#(
   parameter int OUT_W = 330
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             clr,
   input  logic [OUT_W-1:0] resp,
   output logic [31:0]      sig
);
   localparam int NC   = words(OUT_W);
   localparam int PADW = NC * 32;

   logic [PADW-1:0] pad;
   logic [31:0]     fold;
   logic [31:0]     sig_d, sig_q;

   always_comb begin
      pad  = PADW'(resp);
      fold = '0;
      for (int c = 0; c < NC; c++) fold = fold ^ pad[32*c +: 32];
      sig_d = sig_q;
      if (clr)
         sig_d = '0;
      else if (en)
         sig_d = {sig_q[30:0], 1'b0} ^ (sig_q[31] ? MISR_POLY : 32'h0) ^ fold;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sig_q <= '0;
      else        sig_q <= sig_d;
   end

   assign sig = sig_q;
endmodule

// File: rtl/lcg_stim_driver.sv
// LCG/hold/walking-one stimulus sequencer with DUT reset control and response MISR.
// First stim_valid max(RST_CYC,NW)+1 clocks after start, then one every NW clocks; no backpressure.
module lcg_stim_driver
   import fuzz_pkg::*;
#(
   parameter int          IN_W     = 267,
   parameter int          OUT_W    = 330,
   parameter logic [31:0] SEED_DEF = 32'd817804383,
   parameter int          RST_CYC  = 2,
   parameter int          CNT_W    = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               seed_load,
   input  logic [31:0]        seed,
   input  logic [1:0]         mode,
   input  logic [CNT_W-1:0]   cycles,
   lcg_stim_driver_if.master  bus,
   output logic               busy,
   output logic               done,
   output logic [CNT_W-1:0]   vec_count,
   output logic [31:0]        signature
);
   localparam int NW   = words(IN_W);
   localparam int WI_W = (NW > 1) ? $clog2(NW) : 1;
   localparam int WK_W = (IN_W > 1) ? $clog2(IN_W) : 1;

   state_e            state_d, state_q;
   mode_e             fmode_d, fmode_q, fill_mode;
   logic [31:0]       lcg_d, lcg_q, lcg_nxt, rcnt_d, rcnt_q;
   logic [IN_W-1:0]   stage_d, stage_q, stim_d, stim_q, walk_vec;
   logic [WI_W-1:0]   widx_d, widx_q;
   logic [WK_W-1:0]   walk_d, walk_q;
   logic [CNT_W-1:0]  cyc_d, cyc_q, vec_cnt_d, vec_cnt_q;
   logic              fill_done_d, fill_done_q, stim_vld_d, stim_vld_q;
   logic              dut_rst_n_d, dut_rst_n_q, busy_d, busy_q, done_d, done_q;
   logic              fill_step, copy, live, misr_en, misr_clr;

   always_comb begin
      state_d     = state_q;
      fmode_d     = fmode_q;
      lcg_d       = lcg_q;
      rcnt_d      = rcnt_q;
      stage_d     = stage_q;
      stim_d      = stim_q;
      widx_d      = widx_q;
      walk_d      = walk_q;
      cyc_d       = cyc_q;
      vec_cnt_d   = vec_cnt_q;
      fill_done_d = fill_done_q;
      stim_vld_d  = 1'b0;
      dut_rst_n_d = dut_rst_n_q;
      fill_step   = 1'b0;
      copy        = 1'b0;
      misr_en     = 1'b0;
      misr_clr    = 1'b0;
      walk_vec    = '0;
      walk_vec[walk_q] = 1'b1;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (seed_load) lcg_d = seed;
            if (start) begin
               state_d     = ST_RESET;
               rcnt_d      = 32'(RST_CYC);
               cyc_d       = cycles;
               fmode_d     = mode_e'(mode);
               walk_d      = '0;
               vec_cnt_d   = '0;
               widx_d      = '0;
               fill_done_d = 1'b0;
               dut_rst_n_d = 1'b0;
               misr_clr    = 1'b1;
            end
         end
         ST_RESET: begin
            fill_step = !fill_done_q;
            if (rcnt_q <= 32'd1) begin
               dut_rst_n_d = 1'b1;
               state_d     = ST_PRIME;
            end else begin
               rcnt_d = rcnt_q - 32'd1;
            end
         end
         ST_PRIME: begin
            if (dut_rst_n_q && fill_done_q) begin
               if (cyc_q == '0) state_d = ST_DONE;
               else begin
                  copy    = 1'b1;
                  state_d = ST_RUN;
               end
            end else begin
               fill_step = !fill_done_q;
            end
         end
         ST_RUN: begin
            if (!fill_done_q) fill_step = 1'b1;
            else if (vec_cnt_q == cyc_q) begin
               misr_en = 1'b1;
               state_d = ST_DONE;
            end else copy = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase

      // A copy closes one fill and opens the next on the same edge.
      fill_mode = fmode_q;
      if (copy) begin
         stim_d      = (fmode_q == MODE_WALK) ? walk_vec : stage_q;
         stim_vld_d  = 1'b1;
         misr_en     = 1'b1;
         vec_cnt_d   = vec_cnt_q + CNT_W'(1);
         walk_d      = (walk_q == WK_W'(IN_W - 1)) ? '0 : walk_q + WK_W'(1);
         widx_d      = '0;
         fill_done_d = 1'b0;
         fill_step   = 1'b1;
         fill_mode   = mode_e'(mode);
         fmode_d     = fill_mode;
      end

      // The fill after the last vector only paces done; it must not consume LCG words.
      live    = (vec_cnt_d != cyc_q);
      lcg_nxt = lcg_step(lcg_q);
      if (fill_step) begin
         if (live && fill_mode != MODE_HOLD) begin
            lcg_d = lcg_nxt;
            for (int b = 0; b < 32; b++)
               if (32 * int'(widx_d) + b < IN_W) stage_d[32 * int'(widx_d) + b] = lcg_nxt[b];
         end
         fill_done_d = (widx_d == WI_W'(NW - 1));
         widx_d      = widx_d + WI_W'(1);
      end

      busy_d = (state_d == ST_RESET) || (state_d == ST_PRIME) || (state_d == ST_RUN);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         fmode_q     <= MODE_LCG;
         lcg_q       <= SEED_DEF;
         rcnt_q      <= '0;
         stage_q     <= '0;
         stim_q      <= '0;
         widx_q      <= '0;
         walk_q      <= '0;
         cyc_q       <= '0;
         vec_cnt_q   <= '0;
         fill_done_q <= 1'b0;
         stim_vld_q  <= 1'b0;
         dut_rst_n_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         fmode_q     <= fmode_d;
         lcg_q       <= lcg_d;
         rcnt_q      <= rcnt_d;
         stage_q     <= stage_d;
         stim_q      <= stim_d;
         widx_q      <= widx_d;
         walk_q      <= walk_d;
         cyc_q       <= cyc_d;
         vec_cnt_q   <= vec_cnt_d;
         fill_done_q <= fill_done_d;
         stim_vld_q  <= stim_vld_d;
         dut_rst_n_q <= dut_rst_n_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   resp_misr #(.OUT_W(OUT_W)) u_misr (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (misr_en),
      .clr   (misr_clr),
      .resp  (bus.resp),
      .sig   (signature)
   );

   assign bus.stim       = stim_q;
   assign bus.stim_valid = stim_vld_q;
   assign bus.dut_rst_n  = dut_rst_n_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign vec_count      = vec_cnt_q;
endmodule

// File: tb/tb_lcg_stim_driver.sv
// Randomized bench: a wide instance against a word-stream LCG/MISR model, a narrow one for walking-one.
module tb_lcg_stim_driver;
   localparam int          NWA      = 9;
   localparam int          LA       = 10;
   localparam int          RC       = 2;
   localparam logic [31:0] SEED_DEF = 32'd817804383;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   logic        start_a, seed_load_a, busy_a, done_a;
   logic [31:0] seed_a, cycles_a, vcnt_a, sig_a;
   logic [1:0]  mode_a;
   logic        start_b, seed_load_b, busy_b, done_b;
   logic [31:0] seed_b, cycles_b, vcnt_b, sig_b;
   logic [1:0]  mode_b;

   lcg_stim_driver_if #(.IN_W(267), .OUT_W(330)) bus_a ();
   lcg_stim_driver_if #(.IN_W(8),   .OUT_W(16))  bus_b ();

   lcg_stim_driver u_dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .seed_load(seed_load_a), .seed(seed_a),
      .mode(mode_a), .cycles(cycles_a), .bus(bus_a), .busy(busy_a), .done(done_a),
      .vec_count(vcnt_a), .signature(sig_a)
   );

   lcg_stim_driver #(.IN_W(8), .OUT_W(16)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .seed_load(seed_load_b), .seed(seed_b),
      .mode(mode_b), .cycles(cycles_b), .bus(bus_b), .busy(busy_b), .done(done_b),
      .vec_count(vcnt_b), .signature(sig_b)
   );

   int n_chk = 0;
   int n_err = 0;

   logic [31:0]  m_lcg, m_sig;
   logic [266:0] m_stage, m_cur;

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] lcg_f(input logic [31:0] x);
      return x * 32'h41C64E6D + 32'h3039;
   endfunction

   function automatic logic [31:0] misr_f(input logic [31:0] s, input logic [329:0] r);
      logic [351:0] p;
      logic [31:0]  f;
      p = '0;
      p[329:0] = r;
      f = '0;
      for (int i = 0; i < 11; i++) f = f ^ p[i*32 +: 32];
      return {s[30:0], 1'b0} ^ (s[31] ? 32'h04C11DB7 : 32'h0) ^ f;
   endfunction

   function automatic logic [329:0] gen_resp(input int rmode);
      logic [351:0] t;
      for (int i = 0; i < 11; i++) t[i*32 +: 32] = $urandom;
      if (rmode == 1) return '0;
      if (rmode == 2) return 330'd1;
      return t[329:0];
   endfunction

   task automatic chk_rst();
      chk("rst_stim", 512'(bus_a.stim), 512'(0));
      chk("rst_vld",  512'(bus_a.stim_valid), 512'(0));
      chk("rst_dutn", 512'(bus_a.dut_rst_n), 512'(0));
      chk("rst_busy", 512'(busy_a), 512'(0));
      chk("rst_done", 512'(done_a), 512'(0));
      chk("rst_vcnt", 512'(vcnt_a), 512'(0));
      chk("rst_sig",  512'(sig_a), 512'(0));
   endtask

   // One run on instance A, checked every clock against the model.
   task automatic run_a(input int n, input logic [1:0] md, input int rmode,
                        input bit ld, input logic [31:0] sd);
      int           tdone, k;
      bit           exp_v;
      logic [329:0] r;
      logic [287:0] wv;
      start_a = 1'b1; cycles_a = 32'(n); mode_a = md; seed_load_a = ld; seed_a = sd;
      if (ld) m_lcg = sd;
      m_sig = '0;
      bus_a.resp = gen_resp(rmode);
      @(posedge clk); #1;
      start_a = 1'b0; seed_load_a = 1'b0;
      tdone = (n == 0) ? LA : LA + n * NWA;
      for (int t = 1; t <= tdone; t++) begin
         r = gen_resp(rmode);
         bus_a.resp = r;
         @(posedge clk); #1;
         exp_v = (n > 0) && (t >= LA) && (t < tdone) && (((t - LA) % NWA) == 0);
         if (exp_v) begin
            k = (t - LA) / NWA;
            m_sig = misr_f(m_sig, r);
            if (md != 2'd1) begin
               for (int w = 0; w < NWA; w++) begin
                  m_lcg = lcg_f(m_lcg);
                  wv[w*32 +: 32] = m_lcg;
               end
               m_stage = wv[266:0];
            end
            m_cur = (md == 2'd2) ? (267'(1) << k) : m_stage;
         end
         if (n > 0 && t == tdone) m_sig = misr_f(m_sig, r);
         chk("vld",  512'(bus_a.stim_valid), 512'(exp_v));
         chk("stim", 512'(bus_a.stim), 512'(m_cur));
         chk("dutn", 512'(bus_a.dut_rst_n), 512'(t >= RC));
         chk("busy", 512'(busy_a), 512'(t < tdone));
         chk("done", 512'(done_a), 512'(t >= tdone));
         chk("sig",  512'(sig_a), 512'(m_sig));
      end
      chk("vcnt", 512'(vcnt_a), 512'(n));
   endtask

   initial begin
      logic [31:0] x;
      logic [7:0]  wb;
      int          kb, first;
      rst_n = 1'b0;
      start_a = 0; seed_load_a = 0; seed_a = 0; mode_a = 0; cycles_a = 0;
      start_b = 0; seed_load_b = 0; seed_b = 0; mode_b = 0; cycles_b = 0;
      bus_a.resp = '0; bus_b.resp = '0;
      repeat (3) @(posedge clk);
      #1;
      chk_rst();
      rst_n = 1'b1;
      m_lcg = SEED_DEF; m_stage = '0; m_cur = '0; m_sig = '0;
      @(posedge clk); #1;

      seed_a = 32'h0; seed_load_a = 1'b1;
      @(posedge clk); #1;
      seed_load_a = 1'b0; m_lcg = 32'h0;
      run_a(1, 2'd0, 0, 1'b0, 32'h0);
      chk("w0", 512'(bus_a.stim[31:0]), 512'(32'h00003039));
      chk("w1", 512'(bus_a.stim[63:32]), 512'(32'hD3DC167E));
      x = 32'h0;
      repeat (9) x = lcg_f(x);
      chk("w8", 512'(bus_a.stim[266:256]), 512'(x[10:0]));

      run_a(5, 2'd3, 0, 1'b0, 32'h0);
      run_a(3, 2'd1, 0, 1'b0, 32'h0);
      run_a(2, 2'd0, 0, 1'b0, 32'h0);
      run_a(2, 2'd0, 1, 1'b0, 32'h0);
      chk("sig_zero", 512'(sig_a), 512'(0));
      run_a(2, 2'd0, 2, 1'b0, 32'h0);
      chk("sig_one", 512'(sig_a), 512'(7));
      run_a(0, 2'd0, 0, 1'b0, 32'h0);
      run_a(3, 2'd2, 0, 1'b0, 32'h0);
      run_a(2, 2'd0, 0, 1'b1, $urandom);

      start_b = 1'b1; mode_b = 2'd2; cycles_b = 32'd10;
      @(posedge clk); #1;
      start_b = 1'b0;
      kb = 0; first = -1;
      for (int t = 1; t <= 40 && !done_b; t++) begin
         @(posedge clk); #1;
         if (bus_b.stim_valid) begin
            if (first < 0) first = t;
            wb = 8'd1 << (kb % 8);
            chk("walk_b", 512'(bus_b.stim), 512'(wb));
            kb++;
         end
      end
      chk("walk_b_first", 512'(first), 512'(3));
      chk("walk_b_n",     512'(kb), 512'(10));
      chk("walk_b_done",  512'(done_b), 512'(1));
      chk("walk_b_busy",  512'(busy_b), 512'(0));
      chk("walk_b_vcnt",  512'(vcnt_b), 512'(10));
      chk("walk_b_sig",   512'(sig_b), 512'(0));
      chk("walk_b_dutn",  512'(bus_b.dut_rst_n), 512'(1));

      start_a = 1'b1; cycles_a = 32'd5; mode_a = 2'd0;
      @(posedge clk); #1;
      start_a = 1'b0;
      repeat (15) @(posedge clk);
      #1;
      chk("mid_busy", 512'(busy_a), 512'(1));
      rst_n = 1'b0;
      #1;
      chk_rst();
      @(posedge clk); #1;
      rst_n = 1'b1;
      m_lcg = SEED_DEF; m_stage = '0; m_cur = '0;
      run_a(2, 2'd0, 0, 1'b0, 32'h0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
